// File: rtl/ex_div_stage_pkg.sv
// Shared constants for the RV32IM execute stage: operand width, aluop/alusel
// encodings and the divider state type.
package ex_div_stage_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_ITERS = XLEN;

   localparam logic [XLEN-1:0] ZERO_WORD    = '0;
   localparam logic [4:0]      NOP_REG_ADDR = 5'd0;

   // Result classes
   localparam logic [2:0] EXE_RES_NOP   = 3'd0;
   localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
   localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
   localparam logic [2:0] EXE_RES_ARITH = 3'd3;
   localparam logic [2:0] EXE_RES_JUMP  = 3'd4;
   localparam logic [2:0] EXE_RES_MUL   = 3'd5;
   localparam logic [2:0] EXE_RES_DIV   = 3'd6;

   // Operation codes
   localparam logic [7:0] EXE_AND_OP    = 8'h01;
   localparam logic [7:0] EXE_OR_OP     = 8'h02;
   localparam logic [7:0] EXE_XOR_OP    = 8'h03;
   localparam logic [7:0] EXE_LUI_OP    = 8'h04;
   localparam logic [7:0] EXE_SLL_OP    = 8'h10;
   localparam logic [7:0] EXE_SRL_OP    = 8'h11;
   localparam logic [7:0] EXE_SRA_OP    = 8'h12;
   localparam logic [7:0] EXE_ADD_OP    = 8'h20;
   localparam logic [7:0] EXE_SUB_OP    = 8'h21;
   localparam logic [7:0] EXE_SLT_OP    = 8'h22;
   localparam logic [7:0] EXE_SLTU_OP   = 8'h23;
   localparam logic [7:0] EXE_AUIPC_OP  = 8'h24;
   localparam logic [7:0] EXE_MUL_OP    = 8'h30;
   localparam logic [7:0] EXE_MULH_OP   = 8'h31;
   localparam logic [7:0] EXE_MULHSU_OP = 8'h32;
   localparam logic [7:0] EXE_MULHU_OP  = 8'h33;
   localparam logic [7:0] EXE_DIV_OP    = 8'h38;
   localparam logic [7:0] EXE_DIVU_OP   = 8'h39;
   localparam logic [7:0] EXE_REM_OP    = 8'h3A;
   localparam logic [7:0] EXE_REMU_OP   = 8'h3B;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/ex_div_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; master drives decode outputs, slave is the EX stage.
interface ex_div_stage_if;
   import ex_div_stage_pkg::*;

   logic [5:0]      stall;
   logic [7:0]      aluop_i;
   logic [2:0]      alusel_i;
   logic [XLEN-1:0] reg1_i;
   logic [XLEN-1:0] reg2_i;
   logic [4:0]      wd_i;
   logic            wreg_i;
   logic [XLEN-1:0] link_address_i;
   logic [XLEN-1:0] inst_i;
   logic [4:0]      wd_o;
   logic            wreg_o;
   logic [XLEN-1:0] wdata_o;
   logic            stallreq_o;

   modport master (
      output stall, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
             link_address_i, inst_i,
      input  wd_o, wreg_o, wdata_o, stallreq_o
   );

   modport slave (
      input  stall, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
             link_address_i, inst_i,
      output wd_o, wreg_o, wdata_o, stallreq_o
   );

endinterface

// File: rtl/ex_div_stage_div_unit.sv
// Iterative restoring divider, one quotient bit per cycle, with RISC-V
// divide-by-zero / overflow shortcuts and sign correction.
module div_unit
   import ex_div_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_signed_op,
   input  logic            i_rem_op,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   input  logic            i_stall_hold,
   output logic [XLEN-1:0] o_result,
   output logic            o_ready,
   output logic            o_busy
);

   localparam int CNT_W = $clog2(DIV_ITERS);

   div_state_e       r_state, w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_rem, r_quo, r_dvs, r_result;
   logic             r_neg_quo, r_neg_rem, r_rem_op;

   logic            w_dvd_neg, w_dvs_neg, w_div_zero, w_overflow, w_last, w_ge;
   logic [XLEN-1:0] w_dvd_abs, w_dvs_abs, w_special_res;
   logic [XLEN-1:0] w_rem_next, w_quo_next, w_final;
   logic [XLEN:0]   w_shift, w_diff;

   assign w_dvd_neg  = i_signed_op & i_dividend[XLEN-1];
   assign w_dvs_neg  = i_signed_op & i_divisor[XLEN-1];
   assign w_dvd_abs  = w_dvd_neg ? -i_dividend : i_dividend;
   assign w_dvs_abs  = w_dvs_neg ? -i_divisor : i_divisor;
   assign w_div_zero = (i_divisor == '0);
   assign w_overflow = i_signed_op && (i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                       && (i_divisor == '1);

   always_comb begin
      if (w_div_zero)
         w_special_res = i_rem_op ? i_dividend : '1;
      else
         w_special_res = i_rem_op ? ZERO_WORD : {1'b1, {(XLEN-1){1'b0}}};
   end

   // Remainder stays below the divisor, so a 33-bit trial subtract suffices
   // and its top bit is the borrow.
   assign w_shift    = {r_rem, r_quo[XLEN-1]};
   assign w_diff     = w_shift - {1'b0, r_dvs};
   assign w_ge       = ~w_diff[XLEN];
   assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
   assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
   assign w_last     = (r_cnt == CNT_W'(DIV_ITERS - 1));

   always_comb begin
      if (r_rem_op)
         w_final = r_neg_rem ? -w_rem_next : w_rem_next;
      else
         w_final = r_neg_quo ? -w_quo_next : w_quo_next;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= DIV_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first; a missing branch
   // would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      o_busy       = 1'b0;
      o_ready      = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            if (i_start) begin
               o_busy       = 1'b1;
               w_next_state = (w_div_zero || w_overflow) ? DIV_DONE : DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            o_busy = 1'b1;
            if (w_last) w_next_state = DIV_DONE;
         end
         DIV_DONE: begin
            o_ready = 1'b1;
            if (!i_stall_hold) w_next_state = DIV_IDLE;
         end
         default: w_next_state = DIV_IDLE;
      endcase
   end

   // NOTE: datapath registers are reset as well so an aborted divide leaves no
   // stale result visible after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_result  <= '0;
         r_neg_quo <= 1'b0;
         r_neg_rem <= 1'b0;
         r_rem_op  <= 1'b0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (i_start) begin
                  r_cnt    <= '0;
                  r_rem_op <= i_rem_op;
                  if (w_div_zero || w_overflow) begin
                     r_result <= w_special_res;
                  end else begin
                     r_rem     <= '0;
                     r_quo     <= w_dvd_abs;
                     r_dvs     <= w_dvs_abs;
                     r_neg_quo <= w_dvd_neg ^ w_dvs_neg;
                     r_neg_rem <= w_dvd_neg;
                  end
               end
            end
            DIV_BUSY: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) r_result <= w_final;
            end
            default: ;
         endcase
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/ex_div_stage.sv
// RV32IM execute stage: combinational ALU/shift/compare/link/MUL result mux
// plus the iterative divider and its pipeline stall request.
module ex_div_stage
   import ex_div_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   ex_div_stage_if.slave bus
);

   logic [XLEN-1:0]       w_logic_res, w_shift_res, w_arith_res, w_mul_res;
   logic [XLEN-1:0]       w_div_result, w_result;
   logic [4:0]            w_shamt;
   logic                  w_mul_a_sx, w_mul_b_sx;
   logic signed [2*XLEN+1:0] w_product;
   logic                  w_div_start, w_div_signed, w_div_rem;
   logic                  w_div_ready, w_div_busy;
   logic                  w_unused;

   assign w_shamt = bus.reg2_i[4:0];

   always_comb begin
      w_logic_res = ZERO_WORD;
      case (bus.aluop_i)
         EXE_AND_OP: w_logic_res = bus.reg1_i & bus.reg2_i;
         EXE_OR_OP:  w_logic_res = bus.reg1_i | bus.reg2_i;
         EXE_XOR_OP: w_logic_res = bus.reg1_i ^ bus.reg2_i;
         EXE_LUI_OP: w_logic_res = bus.reg2_i;
         default:    ;
      endcase
   end

   always_comb begin
      w_shift_res = ZERO_WORD;
      case (bus.aluop_i)
         EXE_SLL_OP: w_shift_res = bus.reg1_i << w_shamt;
         EXE_SRL_OP: w_shift_res = bus.reg1_i >> w_shamt;
         EXE_SRA_OP: w_shift_res = XLEN'($signed(bus.reg1_i) >>> w_shamt);
         default:    ;
      endcase
   end

   always_comb begin
      w_arith_res = ZERO_WORD;
      case (bus.aluop_i)
         EXE_ADD_OP, EXE_AUIPC_OP: w_arith_res = bus.reg1_i + bus.reg2_i;
         EXE_SUB_OP:  w_arith_res = bus.reg1_i - bus.reg2_i;
         EXE_SLT_OP:  w_arith_res = {{(XLEN-1){1'b0}},
                                     $signed(bus.reg1_i) < $signed(bus.reg2_i)};
         EXE_SLTU_OP: w_arith_res = {{(XLEN-1){1'b0}}, bus.reg1_i < bus.reg2_i};
         default:     ;
      endcase
   end

   // 33x33 signed multiply covers all four flavours via the extension bit.
   assign w_mul_a_sx = (bus.aluop_i == EXE_MULH_OP) || (bus.aluop_i == EXE_MULHSU_OP);
   assign w_mul_b_sx = (bus.aluop_i == EXE_MULH_OP);
   assign w_product  = $signed({w_mul_a_sx & bus.reg1_i[XLEN-1], bus.reg1_i})
                     * $signed({w_mul_b_sx & bus.reg2_i[XLEN-1], bus.reg2_i});
   assign w_mul_res  = (bus.aluop_i == EXE_MUL_OP) ? w_product[XLEN-1:0]
                                                   : w_product[2*XLEN-1:XLEN];

   assign w_div_start  = (bus.alusel_i == EXE_RES_DIV);
   assign w_div_signed = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_REM_OP);
   assign w_div_rem    = (bus.aluop_i == EXE_REM_OP) || (bus.aluop_i == EXE_REMU_OP);

   div_unit u_div (
      .clk          (clk),
      .rst          (rst),
      .i_start      (w_div_start),
      .i_signed_op  (w_div_signed),
      .i_rem_op     (w_div_rem),
      .i_dividend   (bus.reg1_i),
      .i_divisor    (bus.reg2_i),
      .i_stall_hold (bus.stall[3]),
      .o_result     (w_div_result),
      .o_ready      (w_div_ready),
      .o_busy       (w_div_busy)
   );

   always_comb begin
      w_result = ZERO_WORD;
      case (bus.alusel_i)
         EXE_RES_LOGIC: w_result = w_logic_res;
         EXE_RES_SHIFT: w_result = w_shift_res;
         EXE_RES_ARITH: w_result = w_arith_res;
         EXE_RES_JUMP:  w_result = bus.link_address_i;
         EXE_RES_MUL:   w_result = w_mul_res;
         EXE_RES_DIV:   w_result = w_div_ready ? w_div_result : ZERO_WORD;
         default:       ;
      endcase
   end

   assign bus.wd_o       = rst ? NOP_REG_ADDR : bus.wd_i;
   assign bus.wreg_o     = rst ? 1'b0 : bus.wreg_i;
   assign bus.wdata_o    = rst ? ZERO_WORD : w_result;
   assign bus.stallreq_o = rst ? 1'b0 : w_div_busy;

   // Trace-only instruction word and stall bits owned by other stages.
   assign w_unused = ^{bus.inst_i, bus.stall[5:4], bus.stall[2:0],
                       w_product[2*XLEN+1:2*XLEN]};

endmodule

// File: doc/ex_div_stage.md
Name: ex_div_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline. Sits between the ID/EX pipeline register and the EX/MEM pipeline register.
- Consumes the registered decode outputs, computes the writeback value, and passes wd/wreg/wdata downstream.
- Single-cycle ALU, shift, compare, link and MUL ops are combinational.
- DIV/DIVU/REM/REMU run on an iterative 1-bit/cycle divider; the block stalls the front of the pipeline through stallreq_o until the quotient or remainder is ready.

Parameters:
XLEN, 32, operand/result width
DIV_ITERS, 32, divider iterations (equals XLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  6  pipeline stall vector from ctrl; bit3 = EX held, bit4 = MEM held
aluop_i  in  8  operation code (`AluOpBus)
alusel_i  in  3  result class (`AluSelBus): NOP/LOGIC/SHIFT/ARITH/JUMP/MUL/DIV
reg1_i  in  32  operand 1 (rs1 value)
reg2_i  in  32  operand 2 (rs2 value or immediate)
wd_i  in  5  destination register
wreg_i  in  1  destination write enable
link_address_i  in  32  return address for JAL/JALR
inst_i  in  32  raw instruction (debug/trace only)
wd_o  out  5  destination to EX/MEM
wreg_o  out  1  write enable to EX/MEM
wdata_o  out  32  result to EX/MEM
stallreq_o  out  1  stall request to ctrl

Behaviour:
- Reset (rst=1, asynchronous): divider FSM = IDLE, iteration counter = 0, datapath registers = 0. Outputs are forced: wd_o=0, wreg_o=0, wdata_o=0, stallreq_o=0.
- wd_o = wd_i and wreg_o = wreg_i, combinationally, for every op.
- LOGIC: AND/OR/XOR/LUI.
- SHIFT: SLL/SRL/SRA, shift amount = reg2_i[4:0].
- ARITH: ADD/SUB/SLT/SLTU (and AUIPC via the operands supplied by decode).
- JUMP: wdata_o = link_address_i.
- NOP: wdata_o = 0.
- All of the above are 0-cycle combinational with stallreq_o=0.
- MUL group: combinational 33x33 signed/unsigned multiply with operands sign- or zero-extended per op; 64-bit product.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- DIV group, FSM states IDLE, BUSY, DONE:
  - IDLE, alusel_i != DIV: stay; stallreq_o=0.
  - IDLE, DIV op, divisor 0: latch the special result, go DONE; stallreq_o=1.
    - DIV/DIVU -> 0xFFFFFFFF.
    - REM/REMU -> dividend.
  - IDLE, DIV op, signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): go DONE; stallreq_o=1.
    - DIV -> 0x80000000.
    - REM -> 0.
  - IDLE, DIV op, normal: latch |dividend|, |divisor| (absolute values for signed ops) and the result sign flags; counter=0; go BUSY; stallreq_o=1.
  - BUSY: one restoring shift-subtract step per cycle; counter++. When counter reaches DIV_ITERS-1 the step completes, the sign-corrected result is latched, and the FSM goes DONE. stallreq_o=1 throughout.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - DONE: wdata_o = latched result; stallreq_o=0.
    - stall[3]=0: go IDLE next edge (instruction leaves EX).
    - stall[3]=1 (downstream hold): remain DONE, hold result, stallreq_o stays 0.
- Latency (stall[3] low):
  - Normal divide: 34 cycles in EX (1 IDLE + 32 BUSY + 1 DONE); result presented in the DONE cycle.
  - Special divide: 2 cycles (IDLE + DONE).
- Inputs are stable while stallreq_o=1, because ctrl holds ID/EX. The divider does not re-sample operands after IDLE.
- Back-to-back divides: the second op is seen in IDLE on the cycle after DONE and starts normally.
- While the FSM is not DONE, wdata_o for a DIV op is 0. EX/MEM receives a bubble during those cycles.
- rst asserted mid-division: abort immediately to IDLE with no partial writeback.

Decomposition:
- defines.v holds the shared constants:
  - EXE_*_OP aluop codes for RV32IM.
  - EXE_RES_* alusel classes.
  - ZeroWord, NOPRegAddr.
  - Divider state encodings DivIdle/DivBusy/DivDone.
- Sub-module div_unit holds the FSM, counter, restoring datapath, special-case detection and sign correction.
  - Interface: clk, rst, start, signed_op, rem_op, dividend, divisor, stall_hold → result, ready, busy.
- ex_div_stage contains the combinational ALU/MUL muxing plus div_unit instantiation and stallreq_o generation.

Test Plan:
- ADD reg1=5, reg2=0xFFFFFFFD, wd=3, wreg=1 -> same cycle wdata_o=2, wd_o=3, wreg_o=1, stallreq_o=0.
- MULH reg1=0x80000000, reg2=2 -> wdata_o=0xFFFFFFFF. MULHU with the same operands -> wdata_o=1.
- DIV reg1=-7 (0xFFFFFFF9), reg2=2 -> stallreq_o high 33 cycles, then one cycle wdata_o=0xFFFFFFFD with stallreq_o=0. REM with the same operands -> 0xFFFFFFFF.
- DIVU reg1=10, reg2=0 -> 2-cycle occupancy, wdata_o=0xFFFFFFFF. REM reg1=0x80000000, reg2=0xFFFFFFFF -> wdata_o=0.
- DIVU 100/7 with stall[3] forced high during DONE for 3 cycles -> wdata_o=14 held for all 3 cycles, stallreq_o=0, IDLE after stall[3] drops.
- Assert rst at BUSY cycle 10 of a divide -> outputs 0 at once. After release, an ADD executes with no stall and the next DIV takes the full 34 cycles.
